crowd_hold_mc: RTL and testbench
================================

# crowd_hold_mc

Multi-channel, parametrised crowd detector for the traffic-light controller. Each channel watches one crowd sensor. After the sensor stays high for a set number of cycles, the channel asserts a hold request to the phase sequencer. A short dip in the sensor does not drop the hold (release hysteresis). A maximum hold time forces a release, followed by a cooldown, so one approach cannot starve the others. Aggregate outputs give the sequencer a single "any hold" flag and the lowest-index holding channel.

## Interface
Parameters:
- CH, 4 — number of channels, ≥2
- CW, 8 — width of every per-channel counter
- ON_CYC, 10 — consecutive high samples needed to assert hold, 1..2^CW-1
- OFF_CYC, 3 — consecutive low samples needed to release hold, 1..2^CW-1
- MAX_HOLD, 50 — maximum cycles HoldVec[i] may stay high, 1..2^CW-1
- COOL_CYC, 20 — cycles a channel ignores its sensor after a timeout, 1..2^CW-1

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- Enable  in  1  global enable; low forces every channel to IDLE synchronously
- CrowdSignal  in  CH  per-channel crowd sensor, already synchronous to Clk
- HoldVec  out  CH  per-channel hold request, registered
- Timeout  out  CH  one-cycle pulse when a channel's hold is force-released, registered
- AnyHold  out  1  OR of HoldVec, combinational from registers
- HoldId  out  $clog2(CH)  lowest index i with HoldVec[i]=1; 0 when none

## Operation
Each channel is independent and has state (IDLE, ARMING, HOLD, RELEASING, COOLDOWN), a phase counter `cnt`, and a hold timer `ht`. All counters are CW bits wide and never wrap, because the parameter bounds keep every count below 2^CW.

Per-channel transitions, evaluated at each rising edge of Clk with Enable=1 (s = CrowdSignal[i]):
- IDLE, cnt=0:
  - s=1 → ARMING, cnt=1.
  - If ON_CYC=1, s=1 goes directly to HOLD with ht=0.
- ARMING:
  - s=0 → IDLE, cnt=0.
  - s=1 and cnt=ON_CYC-1 → HOLD, ht=0, cnt=0.
  - s=1 otherwise → cnt+1.
- HOLD (HoldVec[i]=1):
  - Timeout check comes first: ht=MAX_HOLD-1 → COOLDOWN, cnt=0, Timeout[i]=1 for this one cycle.
  - Otherwise ht+1, and:
    - s=0 → RELEASING, cnt=1.
    - If OFF_CYC=1, s=0 goes to IDLE instead.
- RELEASING (HoldVec[i] still 1):
  - Timeout check comes first, identical to HOLD.
  - Otherwise ht+1, and:
    - s=1 → HOLD, cnt=0.
    - s=0 and cnt=OFF_CYC-1 → IDLE, ht=0.
    - s=0 otherwise → cnt+1.
- COOLDOWN (HoldVec[i]=0):
  - s is ignored.
  - cnt=COOL_CYC-1 → IDLE, cnt=0; otherwise cnt+1.
  - Leaving COOLDOWN always lands in IDLE, even with s=1, so the channel must re-arm from scratch.

Enable and reset:
- Enable=0 at an edge: every channel goes to IDLE, cnt=ht=0, HoldVec=0, Timeout=0. This overrides all transitions, including a timeout that would have fired on the same edge.
- Rst=1 at any time: immediately all channels go to IDLE, all counters to 0, HoldVec=0, Timeout=0. AnyHold=0 and HoldId=0 follow. Reset asserted mid-operation discards all progress.

Aggregate outputs:
- AnyHold = |HoldVec.
- HoldId is a priority encode of HoldVec with the lowest index winning. It is valid only when AnyHold=1 and reads 0 otherwise.

## Timing
- Hold assert: HoldVec[i] rises on the edge at which s has been sampled high on ON_CYC consecutive edges. The count starts from the first high sample taken in IDLE.
- Hold release: HoldVec[i] falls on the edge of the OFF_CYC-th consecutive low sample.
- Maximum hold: HoldVec[i] is high for at most MAX_HOLD cycles. On timeout, HoldVec[i] falls and Timeout[i] rises on the same edge, and Timeout[i] stays high for exactly one cycle.
- Cooldown: lasts COOL_CYC edges. Earliest re-assertion is COOL_CYC+ON_CYC edges after the timeout edge.
- AnyHold and HoldId change in the same cycle as HoldVec, with no extra latency.

## Test plan
Defaults throughout (CH=4, ON_CYC=10, OFF_CYC=3, MAX_HOLD=50, COOL_CYC=20).
- Arming: ch0 high for 9 edges, then low → HoldVec=0 throughout. Then ch0 high for 10 edges → HoldVec[0]=1 after the 10th edge, AnyHold=1, HoldId=0.
- Hysteresis: ch2 in HOLD, low for 2 edges, then high → HoldVec[2] stays 1. Then low for 3 edges → HoldVec[2]=0 after the 3rd low edge.
- Timeout and cooldown: ch1 held high continuously → HoldVec[1] high for exactly 50 cycles; Timeout[1] is a single-cycle pulse on the falling edge of HoldVec[1]. HoldVec[1] re-rises exactly 30 edges after that edge.
- Priority: ch1 and ch3 both holding → HoldId=1. After ch1 releases → HoldId=3, AnyHold=1. After both release → AnyHold=0, HoldId=0.
- Reset and enable:
  - Rst pulsed between edges while ch0 is in HOLD and ch2 is mid-ARMING → HoldVec=0 immediately. After Rst drops, ch2 needs a full 10 high edges to assert.
  - Enable=0 on the edge where ch0 would time out → no Timeout pulse, all outputs 0.

Source files
------------

// File: rtl/crowd_hold_mc_if.sv
// Crowd-detector bundle: global enable and per-channel sensors in,
// per-channel hold/timeout flags and the aggregate hold summary out.
interface crowd_hold_mc_if #(
   parameter int CH = 4
);
   localparam int IDW = $clog2(CH);

   logic            Enable;
   logic [CH-1:0]   CrowdSignal;
   logic [CH-1:0]   HoldVec;
   logic [CH-1:0]   Timeout;
   logic            AnyHold;
   logic [IDW-1:0]  HoldId;

   // Driver side: the phase sequencer / environment.
   modport master (
      output Enable, CrowdSignal,
      input  HoldVec, Timeout, AnyHold, HoldId
   );

   // Detector side.
   modport slave (
      input  Enable, CrowdSignal,
      output HoldVec, Timeout, AnyHold, HoldId
   );
endinterface

// File: rtl/crowd_hold_mc.sv
// Multi-channel crowd detector. Each channel debounces its sensor into a
// hold request with release hysteresis, a hard hold-time limit and a
// post-timeout cooldown. Aggregates give "any hold" and the lowest holder.
module crowd_hold_mc #(
   parameter int CH       = 4,
   parameter int CW       = 8,
   parameter int ON_CYC   = 10,
   parameter int OFF_CYC  = 3,
   parameter int MAX_HOLD = 50,
   parameter int COOL_CYC = 20
) (
   input  logic             Clk,
   input  logic             Rst,
   crowd_hold_mc_if.slave   bus
);
   localparam int IDW = $clog2(CH);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ARMING    = 3'd1;
   localparam logic [2:0] ST_HOLD      = 3'd2;
   localparam logic [2:0] ST_RELEASING = 3'd3;
   localparam logic [2:0] ST_COOLDOWN  = 3'd4;

   // Terminal counts: a phase ends on the edge where the counter reads N-1.
   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
   localparam logic [CW-1:0] HT_LAST   = CW'(MAX_HOLD - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYC - 1);

   logic [2:0]    r_state [CH];
   logic [CW-1:0] r_cnt   [CH];
   logic [CW-1:0] r_ht    [CH];
   logic [CH-1:0] r_hold;
   logic [CH-1:0] r_timeout;
   logic [IDW-1:0] w_hold_id;

   // Per-channel state machines; Enable low parks every channel in IDLE.
   // NOTE: all state here uses non-blocking assignment so every channel
   // sees the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         // NOTE: these per-channel arrays are plain flops, not RAM, so they
         // are reset explicitly; a mid-run reset must discard all progress.
         for (int i = 0; i < CH; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_ht[i]    <= '0;
         end
         r_hold    <= '0;
         r_timeout <= '0;
      end else if (!bus.Enable) begin
         for (int i = 0; i < CH; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_ht[i]    <= '0;
         end
         r_hold    <= '0;
         r_timeout <= '0;
      end else begin
         r_timeout <= '0;
         for (int i = 0; i < CH; i++) begin
            case (r_state[i])
               ST_IDLE: begin
                  if (bus.CrowdSignal[i]) begin
                     if (ON_CYC == 1) begin
                        r_state[i] <= ST_HOLD;
                        r_hold[i]  <= 1'b1;
                        r_ht[i]    <= '0;
                        r_cnt[i]   <= '0;
                     end else begin
                        r_state[i] <= ST_ARMING;
                        r_cnt[i]   <= CW'(1);
                     end
                  end
               end
               ST_ARMING: begin
                  if (!bus.CrowdSignal[i]) begin
                     r_state[i] <= ST_IDLE;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == ON_LAST) begin
                     r_state[i] <= ST_HOLD;
                     r_hold[i]  <= 1'b1;
                     r_ht[i]    <= '0;
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 1'b1;
                  end
               end
               ST_HOLD, ST_RELEASING: begin
                  // The hold-time limit wins over anything the sensor does.
                  if (r_ht[i] == HT_LAST) begin
                     r_state[i]   <= ST_COOLDOWN;
                     r_hold[i]    <= 1'b0;
                     r_timeout[i] <= 1'b1;
                     r_cnt[i]     <= '0;
                     r_ht[i]      <= '0;
                  end else begin
                     r_ht[i] <= r_ht[i] + 1'b1;
                     if (bus.CrowdSignal[i]) begin
                        r_state[i] <= ST_HOLD;
                        r_cnt[i]   <= '0;
                     end else if ((r_state[i] == ST_HOLD && OFF_CYC == 1) ||
                                  (r_state[i] == ST_RELEASING && r_cnt[i] == OFF_LAST)) begin
                        r_state[i] <= ST_IDLE;
                        r_hold[i]  <= 1'b0;
                        r_cnt[i]   <= '0;
                        r_ht[i]    <= '0;
                     end else if (r_state[i] == ST_HOLD) begin
                        r_state[i] <= ST_RELEASING;
                        r_cnt[i]   <= CW'(1);
                     end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                     end
                  end
               end
               ST_COOLDOWN: begin
                  // Sensor ignored; always exits to IDLE so the channel re-arms.
                  if (r_cnt[i] == COOL_LAST) begin
                     r_state[i] <= ST_IDLE;
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + 1'b1;
                  end
               end
               default: begin
                  r_state[i] <= ST_IDLE;
                  r_hold[i]  <= 1'b0;
                  r_cnt[i]   <= '0;
                  r_ht[i]    <= '0;
               end
            endcase
         end
      end
   end

   // Lowest-index holder; scanning downward lets the lowest index win.
   // NOTE: default assigned first so no path leaves w_hold_id unassigned (no latch).
   always_comb begin
      w_hold_id = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (r_hold[i]) w_hold_id = IDW'(i);
      end
   end

   assign bus.HoldVec = r_hold;
   assign bus.Timeout = r_timeout;
   assign bus.AnyHold = |r_hold;
   assign bus.HoldId  = w_hold_id;
endmodule

// File: tb/tb_crowd_hold_mc.sv
// Bench for crowd_hold_mc: a directed vector table, hand-written multi-cycle
// sequences, then randomized traffic compared against a run-length model.
module tb_crowd_hold_mc;
   localparam int CH       = 4;
   localparam int ON_CYC   = 10;
   localparam int OFF_CYC  = 3;
   localparam int MAX_HOLD = 50;
   localparam int COOL_CYC = 20;

   logic clk = 1'b0;
   logic rst;

   crowd_hold_mc_if #(.CH(CH)) bus ();

   crowd_hold_mc #(
      .CH(CH), .CW(8), .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC),
      .MAX_HOLD(MAX_HOLD), .COOL_CYC(COOL_CYC)
   ) dut (
      .Clk(clk),
      .Rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit         en;
      logic [3:0] crowd;
      logic [3:0] hold;
      logic [3:0] to;
      logic       any;
      logic [1:0] id;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: run lengths and remaining times per channel.
   bit m_hold [CH];
   bit m_to   [CH];
   int m_high [CH];
   int m_low  [CH];
   int m_age  [CH];
   int m_cool [CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [3:0] h, input logic [3:0] t,
                             input logic a, input logic [1:0] id);
      check({name, ".hold"}, 32'(bus.HoldVec), 32'(h));
      check({name, ".timeout"}, 32'(bus.Timeout), 32'(t));
      check({name, ".any"}, 32'(bus.AnyHold), 32'(a));
      check({name, ".id"}, 32'(bus.HoldId), 32'(id));
   endtask

   task automatic add(input int n, input bit en, input logic [3:0] crowd, input logic [3:0] hold,
                      input logic [3:0] to, input logic any, input logic [1:0] id);
      vec_t v;
      v.en = en; v.crowd = crowd; v.hold = hold; v.to = to; v.any = any; v.id = id;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_hold[i] = 0; m_to[i] = 0; m_high[i] = 0;
         m_low[i] = 0; m_age[i] = 0; m_cool[i] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.Enable = 1'b1;
      bus.CrowdSignal = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic model_step(input bit en, input logic [CH-1:0] s);
      for (int i = 0; i < CH; i++) begin
         m_to[i] = 0;
         if (!en) begin
            m_hold[i] = 0; m_high[i] = 0; m_low[i] = 0; m_age[i] = 0; m_cool[i] = 0;
         end else if (m_cool[i] > 0) begin
            m_cool[i]--;
         end else if (m_hold[i]) begin
            if (m_age[i] + 1 == MAX_HOLD) begin
               m_hold[i] = 0; m_to[i] = 1; m_cool[i] = COOL_CYC; m_high[i] = 0;
            end else begin
               m_age[i]++;
               if (s[i]) m_low[i] = 0;
               else begin
                  m_low[i]++;
                  if (m_low[i] == OFF_CYC) begin
                     m_hold[i] = 0; m_high[i] = 0;
                  end
               end
            end
         end else if (s[i]) begin
            m_high[i]++;
            if (m_high[i] == ON_CYC) begin
               m_hold[i] = 1; m_age[i] = 0; m_low[i] = 0;
            end
         end else begin
            m_high[i] = 0;
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [3:0] eh, et;
      logic [1:0] eid;
      eh = '0; et = '0; eid = '0;
      for (int i = 0; i < CH; i++) begin
         eh[i] = m_hold[i];
         et[i] = m_to[i];
      end
      for (int i = CH - 1; i >= 0; i--) if (eh[i]) eid = 2'(i);
      check_outs(name, eh, et, |eh, eid);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e, hi, shift;
      bit en;
      logic [CH-1:0] lvl;

      // Directed table: arming, hysteresis on ch2, Enable clearing ch1 arming.
      add(9, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
      add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      add(9, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
      add(1, 1, 4'b0001, 4'b0001, 4'b0000, 1, 0);
      add(2, 1, 4'b0000, 4'b0001, 4'b0000, 1, 0);
      add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      add(9, 1, 4'b0100, 4'b0000, 4'b0000, 0, 0);
      add(1, 1, 4'b0100, 4'b0100, 4'b0000, 1, 2);
      add(2, 1, 4'b0000, 4'b0100, 4'b0000, 1, 2);
      add(1, 1, 4'b0100, 4'b0100, 4'b0000, 1, 2);
      add(2, 1, 4'b0000, 4'b0100, 4'b0000, 1, 2);
      add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
      add(5, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
      add(1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
      add(9, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
      add(1, 1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
      add(1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);

      rst = 1'b1;
      bus.Enable = 1'b1;
      bus.CrowdSignal = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset_state", 4'b0000, 4'b0000, 0, 0);
      rst = 1'b0;

      foreach (tbl[k]) begin
         bus.Enable = tbl[k].en;
         bus.CrowdSignal = tbl[k].crowd;
         step();
         check_outs($sformatf("vec%0d", k), tbl[k].hold, tbl[k].to, tbl[k].any, tbl[k].id);
      end

      // Timeout and cooldown on ch1 held high continuously.
      do_reset();
      bus.CrowdSignal = 4'b0010;
      e = 0;
      do begin step(); e++; end while (!bus.HoldVec[1] && e < 40);
      check("to.arm_edges", 32'(e), 32'(ON_CYC));
      hi = 0;
      while (bus.HoldVec[1] && hi < 200) begin
         check("to.no_early_pulse", 32'(bus.Timeout), 32'd0);
         hi++;
         step();
      end
      check("to.hold_cycles", 32'(hi), 32'(MAX_HOLD));
      check("to.pulse", 32'(bus.Timeout), 32'b0010);
      check("to.hold_drop", 32'(bus.HoldVec), 32'd0);
      step();
      e = 1;
      check("to.pulse_width", 32'(bus.Timeout), 32'd0);
      while (!bus.HoldVec[1] && e < 60) begin step(); e++; end
      check("to.reassert_edges", 32'(e), 32'(COOL_CYC + ON_CYC));

      // Priority: ch1 and ch3 holding, then released one by one.
      do_reset();
      bus.CrowdSignal = 4'b1010;
      repeat (10) step();
      check_outs("prio.both", 4'b1010, 4'b0000, 1, 1);
      bus.CrowdSignal = 4'b1000;
      repeat (2) step();
      check_outs("prio.ch1_dip", 4'b1010, 4'b0000, 1, 1);
      step();
      check_outs("prio.ch3_only", 4'b1000, 4'b0000, 1, 3);
      bus.CrowdSignal = 4'b0000;
      repeat (3) step();
      check_outs("prio.none", 4'b0000, 4'b0000, 0, 0);

      // Asynchronous reset mid-operation: ch0 holding, ch2 mid-arming.
      do_reset();
      bus.CrowdSignal = 4'b0001;
      repeat (10) step();
      check_outs("rst.ch0_hold", 4'b0001, 4'b0000, 1, 0);
      bus.CrowdSignal = 4'b0101;
      repeat (4) step();
      #3 rst = 1'b1;
      #1;
      check_outs("rst.immediate", 4'b0000, 4'b0000, 0, 0);
      #1 rst = 1'b0;
      bus.CrowdSignal = 4'b0100;
      repeat (9) step();
      check_outs("rst.rearm9", 4'b0000, 4'b0000, 0, 0);
      step();
      check_outs("rst.rearm10", 4'b0100, 4'b0000, 1, 2);

      // Enable low on the very edge where ch0 would time out.
      do_reset();
      bus.CrowdSignal = 4'b0001;
      repeat (MAX_HOLD + ON_CYC - 1) step();
      check_outs("en.pre_timeout", 4'b0001, 4'b0000, 1, 0);
      bus.Enable = 1'b0;
      step();
      check_outs("en.suppressed", 4'b0000, 4'b0000, 0, 0);
      bus.Enable = 1'b1;
      repeat (9) step();
      check_outs("en.no_cooldown9", 4'b0000, 4'b0000, 0, 0);
      step();
      check_outs("en.no_cooldown10", 4'b0001, 4'b0000, 1, 0);

      // Randomized traffic against the run-length model.
      do_reset();
      lvl = '0;
      shift = 2;
      for (int c = 0; c < 4000; c++) begin
         if (c % 256 == 0) shift = $urandom_range(2, 6);
         for (int k = 0; k < CH; k++)
            if ($urandom_range(0, (1 << shift) - 1) == 0) lvl[k] = ~lvl[k];
         en = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #1;
            model_reset();
            check_model("rnd.reset");
            rst = 1'b0;
         end
         bus.Enable = en;
         bus.CrowdSignal = lvl;
         step();
         model_step(en, lvl);
         check_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
